fib_bcd_conv: RTL and testbench
===============================

# fib_bcd_conv

Sequential binary-to-BCD converter that sits directly downstream of the `fib` Fibonacci engine. It accepts the 20-bit result `f` with the same start/ready/done_tick handshake and converts it with an iterative shift-add-3 (double dabble) datapath. It presents seven packed BCD digits to the display/report stage. Conversion uses one bit per cycle, so there is no wide combinational divider.

## Interface
- `W` — default 20 — binary input width; must match `fib.f`.
- `D` — default 7 — BCD digit count; must satisfy 10^D > 2^W − 1.
- `clk`  in  1  — single clock; all state changes on the rising edge.
- `reset`  in  1  — synchronous, active-low reset; sampled on the `clk` rising edge.
- `start`  in  1  — request a conversion; sampled only while `ready`=1.
- `bin`  in  W  — binary value to convert; typically `fib.f`; captured on accept.
- `ready`  out  1  — 1 while idle and able to accept `start`.
- `done_tick`  out  1  — one-cycle pulse; `bcd` is valid from this cycle on.
- `bcd`  out  4·D  — packed BCD result; digit 0 (units) in bits [3:0].

## Operation
- FSM states: IDLE, OP, DONE.
- **IDLE**
  - `ready`=1.
  - On an edge with `start`=1: capture `bin` into the shift register, clear the BCD accumulator, load iteration counter `n`=W−1, go to OP.
- **OP**, each cycle:
  - Add 3 to every accumulator digit ≥ 5.
  - Then shift {accumulator, shift register} left by 1.
  - If `n`==0, go to DONE and load `bcd` from the final accumulator.
  - Otherwise decrement `n`.
- **DONE**
  - `done_tick`=1 for exactly this cycle.
  - Unconditionally go to IDLE on the next edge.
- `start` is ignored in OP and DONE; there is no queueing.
- `bin` may change at any time after the accept edge.
- `bcd` holds its value until the next DONE load.
- Width rules:
  - Accumulator is 4·D bits.
  - The add-3 is per digit, 4-bit, with no carry between digits; no digit exceeds 9 after the shift.
  - The counter is ⌈log2 W⌉ bits.
- `ready` and `done_tick` are decoded from the state register, not registered separately.

## Timing
- **Reset.** `reset`=0 at an edge forces IDLE, `bcd`=0, counter=0.
  - Reset values: `ready`=1, `done_tick`=0.
  - Reset mid-conversion aborts with no `done_tick`; reset has priority over `start`.
- **Latency.** With the accept at edge 0:
  - OP iterations occur at edges 1..W.
  - DONE occupies the cycle after edge W, so `done_tick` is high W+1 cycles after accept (21 for W=20).
  - `ready` returns one cycle later.
- **Throughput.** One conversion per W+2 cycles. A `start` held high is accepted in the first IDLE cycle after DONE.
- **Input value 0.** Still takes the full W iterations; there is no early exit.

## Configuration
- `FIB_BCD_BLANK_EN`
  - **Defined:** when `bcd` is loaded, every leading zero digit above digit 0 is replaced with 4'hF (blank code). Digit 0 is never blanked. Example: 21 → 28'hFFFFF21.
  - **Undefined:** `bcd` carries plain BCD with leading zeros.
  - Reset value of `bcd` is 0 in both cases.
  - Latency is identical in both cases.

## Test plan
- **Basic value.** Reset low 2 cycles, then `bin`=21, `start` pulse → `done_tick` exactly 21 cycles after accept, `bcd`=28'h0000021 (blank: 28'hFFFFF21), `ready` high the cycle after.
- **Extremes.** `bin`=0 → `bcd`=28'h0000000 (blank: 28'hFFFFFF0). `bin`=20'hFFFFF → `bcd`=28'h1048575.
- **Fibonacci sweep.** Drive i=0..25 through `fib`, feeding `f`→`bin` and `fib.done_tick`→`start` → each `bcd` equals the decimal Fibonacci value, e.g. i=25 → 28'h0075025.
- **Busy ignore.** Assert `start` with `bin`=99 during OP of a `bin`=8 conversion → exactly one `done_tick`, `bcd`=28'h0000008.
- **Reset mid-conversion.** `reset`=0 at iteration 10 → `bcd`=0, `ready`=1 next cycle, no `done_tick`; a following `bin`=144 conversion gives 28'h0000144.
- **Back-to-back.** Hold `start` high with `bin`=55 → `done_tick` pulses every 22 cycles, each with `bcd`=28'h0000055.

Source files
------------

// File: rtl/fib_bcd_conv_if.sv
// ============================================================================
//  Module      : fib_bcd_conv_if
//  Description : start/ready/done_tick handshake plus data buses between a
//                requester (master) and the binary-to-BCD converter (slave).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface fib_bcd_conv_if #(
  parameter int W = 20,
  parameter int D = 7
);
  logic             start;
  logic [W-1:0]     bin;
  logic             ready;
  logic             done_tick;
  logic [4*D-1:0]   bcd;

  modport master (
    output start, bin,
    input  ready, done_tick, bcd
  );

  modport slave (
    input  start, bin,
    output ready, done_tick, bcd
  );
endinterface

`default_nettype wire

// File: rtl/fib_bcd_conv.sv
// ============================================================================
//  Module      : fib_bcd_conv
//  Description : Iterative binary-to-BCD converter (double dabble), one input
//                bit per cycle. Accepts a W-bit value on start while ready,
//                pulses done_tick W+1 cycles later with D packed BCD digits.
//                Optional macro FIB_BCD_BLANK_EN replaces leading zero digits
//                above digit 0 with the blank code 4'hF.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module fib_bcd_conv #(
  parameter int W = 20,
  parameter int D = 7
) (
  input  wire logic          clk,
  input  wire logic          reset,
  fib_bcd_conv_if.slave      bus
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam int BW = 4 * D;
  localparam logic [CW-1:0] C_N_INIT = CW'(W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OP   = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic [W-1:0]    r_sh;
  logic [BW-1:0]   r_acc;
  logic [BW-1:0]   r_bcd;
  logic [CW-1:0]   r_n;

  logic [BW-1:0]   w_adj;
  logic [BW-1:0]   w_acc_nxt;
  logic [BW-1:0]   w_load;

  // Per-digit add-3 correction; digits are independent, no carry between them.
  for (genvar i = 0; i < D; i++) begin : g_digit
    assign w_adj[4*i +: 4] = (r_acc[4*i +: 4] >= 4'd5) ? r_acc[4*i +: 4] + 4'd3
                                                       : r_acc[4*i +: 4];
  end

  // Corrected accumulator shifted left with the next binary MSB entering at bit 0.
  // The top bit falling out is always 0 because 10^D exceeds the input range.
  assign w_acc_nxt = BW'({w_adj, r_sh[W-1]});

`ifdef FIB_BCD_BLANK_EN
  logic w_lead;

  // Replace leading zero digits (never digit 0) with the blank code.
  always_comb begin
    w_load = w_acc_nxt;
    w_lead = 1'b1;
    for (int i = D - 1; i >= 1; i--) begin
      if (w_lead && (w_acc_nxt[4*i +: 4] == 4'd0)) begin
        w_load[4*i +: 4] = 4'hF;
      end else begin
        w_lead = 1'b0;
      end
    end
  end
`else
  assign w_load = w_acc_nxt;
`endif

  // Control FSM and shift/accumulate datapath.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_sh    <= '0;
      r_acc   <= '0;
      r_bcd   <= '0;
      r_n     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_sh    <= bus.bin;
            r_acc   <= '0;
            r_n     <= C_N_INIT;
            r_state <= OP;
          end
        end
        OP: begin
          r_acc <= w_acc_nxt;
          r_sh  <= {r_sh[W-2:0], 1'b0};
          if (r_n == '0) begin
            r_bcd   <= w_load;
            r_state <= DONE;
          end else begin
            r_n <= r_n - 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.ready     = (r_state == IDLE);
  assign bus.done_tick = (r_state == DONE);
  assign bus.bcd       = r_bcd;

endmodule

`default_nettype wire

// File: tb/tb_fib_bcd_conv.sv
// ============================================================================
//  Module      : tb_fib_bcd_conv
//  Description : Self-checking bench for fib_bcd_conv: directed vector table,
//                Fibonacci sweep, random values against a decimal model, and
//                busy-ignore / mid-conversion reset / back-to-back sequences.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fib_bcd_conv;

  localparam int W = 20;
  localparam int D = 7;

  logic clk = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  fib_bcd_conv_if #(.W(W), .D(D)) bus ();

  fib_bcd_conv #(.W(W), .D(D)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [19:0] bin;
    logic [27:0] plain;
    logic [27:0] blank;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Decimal reference: digits by division, blanking by decimal digit count.
  function automatic logic [27:0] ref_bcd(input int unsigned v);
    int unsigned t;
    logic [27:0] r;
`ifdef FIB_BCD_BLANK_EN
    int nd;
`endif
    r = '0;
    t = v;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
`ifdef FIB_BCD_BLANK_EN
    t = v;
    nd = 1;
    while (t >= 10) begin
      t = t / 10;
      nd++;
    end
    for (int i = nd; i < D; i++) r[4*i +: 4] = 4'hF;
`endif
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full conversion: latency, result, pulse width, ready return, hold.
  task automatic convert(input logic [19:0] v, input string nm, input logic [27:0] exp);
    int lat;
    bit seen;
    for (int k = 0; k < 50 && bus.ready !== 1'b1; k++) tick();
    check({nm, " ready_before"}, 64'(bus.ready), 64'd1);
    bus.bin   = v;
    bus.start = 1'b1;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      tick();
      lat++;
      if (lat == 1) begin
        bus.start = 1'b0;
        bus.bin   = 20'($urandom);
      end
      if (bus.done_tick === 1'b1) seen = 1'b1;
    end
    check({nm, " latency"}, 64'(lat), 64'd21);
    check({nm, " bcd"}, 64'(bus.bcd), 64'(exp));
    tick();
    check({nm, " ready_after"}, 64'(bus.ready), 64'd1);
    check({nm, " done_one_cycle"}, 64'(bus.done_tick), 64'd0);
    tick();
    check({nm, " bcd_hold"}, 64'(bus.bcd), 64'(exp));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [27:0] exp;
    int unsigned fa, fb, fn;
    int cnt;
    int t0, t1, t2;
    logic [27:0] b0, b1, b2;

    vecs[0] = '{20'd21,      28'h0000021, 28'hFFFFF21};
    vecs[1] = '{20'd0,       28'h0000000, 28'hFFFFFF0};
    vecs[2] = '{20'hFFFFF,   28'h1048575, 28'h1048575};
    vecs[3] = '{20'd8,       28'h0000008, 28'hFFFFFF8};
    vecs[4] = '{20'd144,     28'h0000144, 28'hFFFF144};
    vecs[5] = '{20'd55,      28'h0000055, 28'hFFFFF55};
    vecs[6] = '{20'd99999,   28'h0099999, 28'hFF99999};
    vecs[7] = '{20'd1000000, 28'h1000000, 28'h1000000};

    bus.start = 1'b0;
    bus.bin   = '0;
    reset     = 1'b0;
    tick();
    tick();
    check("reset ready", 64'(bus.ready), 64'd1);
    check("reset done_tick", 64'(bus.done_tick), 64'd0);
    check("reset bcd", 64'(bus.bcd), 64'd0);
    reset = 1'b1;
    tick();

    // Directed table.
    for (int i = 0; i < 8; i++) begin
`ifdef FIB_BCD_BLANK_EN
      exp = vecs[i].blank;
`else
      exp = vecs[i].plain;
`endif
      convert(vecs[i].bin, $sformatf("vec%0d", i), exp);
    end

    // Fibonacci sweep i = 0..25.
    fa = 0;
    fb = 1;
    for (int i = 0; i <= 25; i++) begin
      convert(20'(fa), $sformatf("fib%0d", i), ref_bcd(fa));
      fn = fa + fb;
      fa = fb;
      fb = fn;
    end

    // Random values against the decimal model.
    for (int i = 0; i < 20; i++) begin
      fn = $urandom_range(0, 1048575);
      convert(20'(fn), $sformatf("rnd%0d", i), ref_bcd(fn));
    end

    // Busy ignore: start with bin=99 during OP of a bin=8 conversion.
    bus.bin   = 20'd8;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    cnt = 0;
    for (int k = 0; k < 3; k++) tick();
    bus.start = 1'b1;
    bus.bin   = 20'd99;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (bus.done_tick === 1'b1) cnt++;
    end
    bus.start = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (bus.done_tick === 1'b1) cnt++;
    end
    check("busy done_count", 64'(cnt), 64'd1);
    check("busy bcd", 64'(bus.bcd), 64'(ref_bcd(8)));

    // Reset at iteration 10 aborts the conversion.
    bus.bin   = 20'd500000;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    reset = 1'b0;
    tick();
    check("midreset bcd", 64'(bus.bcd), 64'd0);
    check("midreset ready", 64'(bus.ready), 64'd1);
    check("midreset done_tick", 64'(bus.done_tick), 64'd0);
    reset = 1'b1;
    cnt = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (bus.done_tick === 1'b1) cnt++;
    end
    check("midreset no_done", 64'(cnt), 64'd0);
    convert(20'd144, "after_reset", ref_bcd(144));

    // Back-to-back with start held high.
    bus.bin   = 20'd55;
    bus.start = 1'b1;
    cnt = 0;
    t0 = 0; t1 = 0; t2 = 0;
    b0 = '0; b1 = '0; b2 = '0;
    for (int k = 1; k <= 100 && cnt < 3; k++) begin
      tick();
      if (bus.done_tick === 1'b1) begin
        if (cnt == 0) begin t0 = k; b0 = bus.bcd; end
        else if (cnt == 1) begin t1 = k; b1 = bus.bcd; end
        else begin t2 = k; b2 = bus.bcd; end
        cnt++;
      end
    end
    bus.start = 1'b0;
    check("b2b pulse_count", 64'(cnt), 64'd3);
    check("b2b first_latency", 64'(t0), 64'd21);
    check("b2b period1", 64'(t1 - t0), 64'd22);
    check("b2b period2", 64'(t2 - t1), 64'd22);
    check("b2b bcd0", 64'(b0), 64'(ref_bcd(55)));
    check("b2b bcd1", 64'(b1), 64'(ref_bcd(55)));
    check("b2b bcd2", 64'(b2), 64'(ref_bcd(55)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
